// File: rtl/cluster_periph_router_pkg.sv
// Shared cluster peripheral definitions: slave plug IDs, unmapped-slot
// decode, error response data and the router state encoding.
package cluster_periph_router_pkg;

  localparam int NB_SPERIPHS = 11;

  localparam int SPER_EOC_ID         = 0;
  localparam int SPER_TIMER_ID       = 1;
  localparam int SPER_EVENT_U_ID     = 2;
  localparam int SPER_UNMAPPED_ID    = 3;
  localparam int SPER_HWPE_ID        = 4;
  localparam int SPER_ICACHE_CTRL_ID = 5;
  localparam int SPER_DMA_CL_ID      = 6;
  localparam int SPER_DMA_FC_ID      = 7;
  localparam int SPER_DECOMP_ID      = 8;
  localparam int SPER_EXT_ID         = 9;
  localparam int SPER_LOCKSTEP_ID    = 10;

  localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

  typedef enum logic [1:0] {
    RT_IDLE = 2'd0,
    RT_BUSY = 2'd1,
    RT_ERR  = 2'd2
  } router_state_e;

  // Slot 3 has no plug behind it; anything past the last plug is also unmapped.
  function automatic logic sper_is_unmapped(input logic [3:0] idx, input int nb);
    return (int'(idx) >= nb) || (int'(idx) == SPER_UNMAPPED_ID);
  endfunction

endpackage

// File: rtl/cluster_periph_outstanding_cnt.sv
// Saturating up/down counter of accepted-but-unanswered transactions.
// Simultaneous inc and dec leave the count unchanged.
module cluster_periph_outstanding_cnt #(
  parameter int MAX_CNT = 4,
  localparam int CNT_W  = $clog2(MAX_CNT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [CNT_W-1:0] cnt_q;

  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(MAX_CNT));
  assign empty_o = (cnt_q == '0);

  // Count up on accept, down on response, clamped at both ends.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i && !full_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && !empty_o) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/cluster_periph_router.sv
// Routes the cluster peripheral-interconnect master port to the peripheral
// plugs. Only one target may have transactions in flight at a time, which
// keeps responses in order; unmapped slots get a local error response.
module cluster_periph_router #(
  parameter int NB_SPERIPHS     = cluster_periph_router_pkg::NB_SPERIPHS,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int IDX_LSB         = 10,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              mst_req_i,
  input  logic [ADDR_WIDTH-1:0]             mst_add_i,
  input  logic                              mst_wen_i,
  input  logic [DATA_WIDTH-1:0]             mst_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]           mst_be_i,
  output logic                              mst_gnt_o,
  output logic                              mst_r_valid_o,
  output logic [DATA_WIDTH-1:0]             mst_r_rdata_o,
  output logic                              mst_r_opc_o,
  output logic [NB_SPERIPHS-1:0]            slv_req_o,
  output logic [ADDR_WIDTH-1:0]             slv_add_o,
  output logic                              slv_wen_o,
  output logic [DATA_WIDTH-1:0]             slv_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           slv_be_o,
  input  logic [NB_SPERIPHS-1:0]            slv_gnt_i,
  input  logic [NB_SPERIPHS-1:0]            slv_r_valid_i,
  input  logic [NB_SPERIPHS*DATA_WIDTH-1:0] slv_r_rdata_i,
  input  logic [NB_SPERIPHS-1:0]            slv_r_opc_i,
  output logic                              stray_rsp_o
);

  import cluster_periph_router_pkg::*;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  router_state_e          state_q, state_d;
  logic [3:0]             tgt_q;
  logic [3:0]             idx, idx_sel;
  logic                   mapped;
  logic                   fwd_ok;
  logic                   gnt;
  logic                   acc_map, acc_err;
  logic                   rsp_hit;
  logic [NB_SPERIPHS-1:0] hit_mask;
  logic                   stray_d;
  logic [CNT_W-1:0]       cnt;
  logic                   cnt_full, cnt_empty;

  assign slv_add_o   = mst_add_i;
  assign slv_wen_o   = mst_wen_i;
  assign slv_wdata_o = mst_wdata_i;
  assign slv_be_o    = mst_be_i;

  assign idx     = mst_add_i[IDX_LSB+3:IDX_LSB];
  assign mapped  = !sper_is_unmapped(idx, NB_SPERIPHS);
  // Keeps the grant lookup in range when the index is unmapped.
  assign idx_sel = mapped ? idx : 4'd0;

  // A response from the current target frees a slot in the same cycle, so a
  // full counter does not block a request that arrives with that response.
  assign rsp_hit = (state_q == RT_BUSY) && slv_r_valid_i[tgt_q] && !cnt_empty;
  assign fwd_ok  = mapped && (!cnt_full || rsp_hit) &&
                   ((state_q == RT_IDLE) || ((state_q == RT_BUSY) && (idx == tgt_q)));

  assign acc_map = mst_req_i && gnt && mapped;
  assign acc_err = mst_req_i && gnt && !mapped;
  assign mst_gnt_o = gnt;

  cluster_periph_outstanding_cnt #(
    .MAX_CNT (MAX_OUTSTANDING)
  ) i_outstanding_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (acc_map),
    .dec_i   (rsp_hit),
    .cnt_o   (cnt),
    .full_o  (cnt_full),
    .empty_o (cnt_empty)
  );

  // Request fan-out, grant return, stray detection and next-state decode.
  always_comb begin
    slv_req_o = '0;
    hit_mask  = '0;
    gnt       = 1'b0;
    state_d   = state_q;

    for (int i = 0; i < NB_SPERIPHS; i++) begin
      if (fwd_ok && mst_req_i && (int'(idx) == i)) slv_req_o[i] = 1'b1;
      if (rsp_hit && (int'(tgt_q) == i))          hit_mask[i]  = 1'b1;
    end

    if (mst_req_i) begin
      if (fwd_ok) begin
        gnt = slv_gnt_i[idx_sel];
      end else if (!mapped && (state_q == RT_IDLE)) begin
        gnt = 1'b1;
      end
    end

    stray_d = |(slv_r_valid_i & ~hit_mask);

    unique case (state_q)
      RT_IDLE: begin
        if (acc_map)      state_d = RT_BUSY;
        else if (acc_err) state_d = RT_ERR;
      end
      RT_BUSY: begin
        if (rsp_hit && !acc_map && (cnt == CNT_W'(1))) state_d = RT_IDLE;
      end
      RT_ERR:  state_d = RT_IDLE;
      default: state_d = RT_IDLE;
    endcase
  end

  // State and target tracking; the target is latched only when leaving IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RT_IDLE;
      tgt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if ((state_q == RT_IDLE) && acc_map) tgt_q <= idx;
    end
  end

  // Registered response path: target response or local error, data zeroed when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mst_r_valid_o <= 1'b0;
      mst_r_rdata_o <= '0;
      mst_r_opc_o   <= 1'b0;
      stray_rsp_o   <= 1'b0;
    end else begin
      stray_rsp_o <= stray_d;
      if (rsp_hit) begin
        mst_r_valid_o <= 1'b1;
        mst_r_rdata_o <= slv_r_rdata_i[int'(tgt_q)*DATA_WIDTH +: DATA_WIDTH];
        mst_r_opc_o   <= slv_r_opc_i[tgt_q];
      end else if (acc_err) begin
        mst_r_valid_o <= 1'b1;
        mst_r_rdata_o <= ERR_RDATA;
        mst_r_opc_o   <= 1'b1;
      end else begin
        mst_r_valid_o <= 1'b0;
        mst_r_rdata_o <= '0;
        mst_r_opc_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cluster_periph_router.sv
// Directed bench for cluster_periph_router: per-cycle vector table plus a
// hand-written mid-operation reset sequence.
module tb_cluster_periph_router;

  localparam int NB = 11;
  localparam int DW = 32;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           mst_req_i;
  logic [31:0]    mst_add_i;
  logic           mst_wen_i;
  logic [31:0]    mst_wdata_i;
  logic [3:0]     mst_be_i;
  logic           mst_gnt_o;
  logic           mst_r_valid_o;
  logic [31:0]    mst_r_rdata_o;
  logic           mst_r_opc_o;
  logic [NB-1:0]  slv_req_o;
  logic [31:0]    slv_add_o;
  logic           slv_wen_o;
  logic [31:0]    slv_wdata_o;
  logic [3:0]     slv_be_o;
  logic [NB-1:0]  slv_gnt_i;
  logic [NB-1:0]  slv_r_valid_i;
  logic [NB*DW-1:0] slv_r_rdata_i;
  logic [NB-1:0]  slv_r_opc_i;
  logic           stray_rsp_o;

  int errors = 0;
  int checks = 0;
  int row_no = -1;

  always #5 clk_i = ~clk_i;

  cluster_periph_router dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .mst_req_i     (mst_req_i),
    .mst_add_i     (mst_add_i),
    .mst_wen_i     (mst_wen_i),
    .mst_wdata_i   (mst_wdata_i),
    .mst_be_i      (mst_be_i),
    .mst_gnt_o     (mst_gnt_o),
    .mst_r_valid_o (mst_r_valid_o),
    .mst_r_rdata_o (mst_r_rdata_o),
    .mst_r_opc_o   (mst_r_opc_o),
    .slv_req_o     (slv_req_o),
    .slv_add_o     (slv_add_o),
    .slv_wen_o     (slv_wen_o),
    .slv_wdata_o   (slv_wdata_o),
    .slv_be_o      (slv_be_o),
    .slv_gnt_i     (slv_gnt_i),
    .slv_r_valid_i (slv_r_valid_i),
    .slv_r_rdata_i (slv_r_rdata_i),
    .slv_r_opc_i   (slv_r_opc_i),
    .stray_rsp_o   (stray_rsp_o)
  );

  typedef struct {
    logic          req;
    logic [31:0]   add;
    logic          wen;
    logic [NB-1:0] gnt;
    logic [NB-1:0] rv;
    logic [31:0]   rdata;
    logic          opc;
    logic [NB-1:0] e_req;
    logic          e_gnt;
    logic          e_rv;
    logic [31:0]   e_rdata;
    logic          e_opc;
    logic          e_stray;
  } vec_t;

  vec_t tv[$];

  localparam logic [NB-1:0] N   = 11'h000;
  localparam logic [NB-1:0] B1  = 11'h002;
  localparam logic [NB-1:0] B2  = 11'h004;
  localparam logic [NB-1:0] B6  = 11'h040;
  localparam logic [NB-1:0] B8  = 11'h100;
  localparam logic [NB-1:0] ALL = 11'h7FF;

  task automatic row(input logic req, input logic [31:0] add, input logic wen,
                     input logic [NB-1:0] gnt, input logic [NB-1:0] rv,
                     input logic [31:0] rdata, input logic opc,
                     input logic [NB-1:0] e_req, input logic e_gnt,
                     input logic e_rv, input logic [31:0] e_rdata,
                     input logic e_opc, input logic e_stray);
    vec_t v;
    v.req = req; v.add = add; v.wen = wen; v.gnt = gnt; v.rv = rv;
    v.rdata = rdata; v.opc = opc; v.e_req = e_req; v.e_gnt = e_gnt;
    v.e_rv = e_rv; v.e_rdata = e_rdata; v.e_opc = e_opc; v.e_stray = e_stray;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %h expected %h", name, row_no, act, exp);
    end
  endtask

  // Responding lanes carry the row's data/opc; silent lanes carry junk.
  task automatic drive(input logic req, input logic [31:0] add, input logic wen,
                       input logic [NB-1:0] gnt, input logic [NB-1:0] rv,
                       input logic [31:0] rdata, input logic opc);
    mst_req_i     = req;
    mst_add_i     = add;
    mst_wen_i     = wen;
    mst_wdata_i   = add ^ 32'h5A5A_0000;
    mst_be_i      = 4'hF;
    slv_gnt_i     = gnt;
    slv_r_valid_i = rv;
    for (int i = 0; i < NB; i++) begin
      slv_r_rdata_i[i*DW +: DW] = rv[i] ? rdata : (32'hDEAD_0000 | 32'(i));
      slv_r_opc_i[i]            = rv[i] ? opc : 1'b1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt"},   32'(mst_gnt_o),     32'd0);
    chk({tag, " rv"},    32'(mst_r_valid_o), 32'd0);
    chk({tag, " rdata"}, mst_r_rdata_o,      32'd0);
    chk({tag, " opc"},   32'(mst_r_opc_o),   32'd0);
    chk({tag, " req"},   32'(slv_req_o),     32'd0);
    chk({tag, " stray"}, 32'(stray_rsp_o),   32'd0);
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0, 32'h0, 0, N, N, 32'h0, 0);

    // Timer read, completes in one round trip.
    row(1, 32'h400, 1, B1, N,  32'h0,    0, B1, 1, 0, 32'h0,    0, 0);
    row(0, 32'h0,   0, N,  B1, 32'h1234, 0, N,  0, 0, 32'h0,    0, 0);
    row(0, 32'h0,   0, N,  N,  32'h0,    0, N,  0, 1, 32'h1234, 0, 0);
    row(0, 32'h0,   0, N,  N,  32'h0,    0, N,  0, 0, 32'h0,    0, 0);
    // Four writes to DMA_CL fill the counter; fifth waits; response reopens.
    row(1, 32'h1800, 0, B6, N,  32'h0,  0, B6, 1, 0, 32'h0,  0, 0);
    row(1, 32'h1800, 0, B6, N,  32'h0,  0, B6, 1, 0, 32'h0,  0, 0);
    row(1, 32'h1800, 0, B6, N,  32'h0,  0, B6, 1, 0, 32'h0,  0, 0);
    row(1, 32'h1800, 0, B6, N,  32'h0,  0, B6, 1, 0, 32'h0,  0, 0);
    row(1, 32'h1800, 0, B6, N,  32'h0,  0, N,  0, 0, 32'h0,  0, 0);
    row(1, 32'h1800, 0, B6, B6, 32'hA0, 0, B6, 1, 0, 32'h0,  0, 0);
    row(0, 32'h0,    0, N,  N,  32'h0,  0, N,  0, 1, 32'hA0, 0, 0);
    row(0, 32'h0,    0, N,  B6, 32'hB1, 0, N,  0, 0, 32'h0,  0, 0);
    row(0, 32'h0,    0, N,  B6, 32'hB2, 0, N,  0, 1, 32'hB1, 0, 0);
    row(0, 32'h0,    0, N,  B6, 32'hB3, 0, N,  0, 1, 32'hB2, 0, 0);
    row(0, 32'h0,    0, N,  B6, 32'hB4, 1, N,  0, 1, 32'hB3, 0, 0);
    row(0, 32'h0,    0, N,  N,  32'h0,  0, N,  0, 1, 32'hB4, 1, 0);
    // Two timer transactions outstanding; EU held off until they drain.
    row(1, 32'h400, 1, B1, N,  32'h0,  0, B1, 1, 0, 32'h0,  0, 0);
    row(1, 32'h400, 1, B1, N,  32'h0,  0, B1, 1, 0, 32'h0,  0, 0);
    row(1, 32'h800, 1, B2, N,  32'h0,  0, N,  0, 0, 32'h0,  0, 0);
    row(1, 32'h800, 1, B2, B1, 32'h11, 0, N,  0, 0, 32'h0,  0, 0);
    row(1, 32'h800, 1, B2, B1, 32'h22, 0, N,  0, 1, 32'h11, 0, 0);
    row(1, 32'h800, 1, B2, N,  32'h0,  0, B2, 1, 1, 32'h22, 0, 0);
    row(0, 32'h0,   0, N,  B2, 32'h33, 0, N,  0, 0, 32'h0,  0, 0);
    row(0, 32'h0,   0, N,  N,  32'h0,  0, N,  0, 1, 32'h33, 0, 0);
    // Unmapped idx 3 and idx 12: local error response, no slave request.
    row(1, 32'hC00,  1, ALL, N, 32'h0, 0, N, 1, 0, 32'h0,        0, 0);
    row(1, 32'hC00,  1, ALL, N, 32'h0, 0, N, 0, 1, 32'hBADACCE5, 1, 0);
    row(1, 32'h3000, 1, ALL, N, 32'h0, 0, N, 1, 0, 32'h0,        0, 0);
    row(0, 32'h0,    0, N,   N, 32'h0, 0, N, 0, 1, 32'hBADACCE5, 1, 0);
    // Accept + response at cnt 2, then a stray from slave 8; cnt must stay 2.
    row(1, 32'h400, 1, B1, N,  32'h0,  0, B1, 1, 0, 32'h0,  0, 0);
    row(1, 32'h400, 1, B1, N,  32'h0,  0, B1, 1, 0, 32'h0,  0, 0);
    row(1, 32'h400, 1, B1, B1, 32'h55, 0, B1, 1, 0, 32'h0,  0, 0);
    row(0, 32'h0,   0, N,  B8, 32'h66, 0, N,  0, 1, 32'h55, 0, 0);
    row(0, 32'h0,   0, N,  N,  32'h0,  0, N,  0, 0, 32'h0,  0, 1);
    row(0, 32'h0,   0, N,  B1, 32'h77, 0, N,  0, 0, 32'h0,  0, 0);
    row(0, 32'h0,   0, N,  B1, 32'h88, 0, N,  0, 1, 32'h77, 0, 0);
    row(1, 32'h800, 1, B2, N,  32'h0,  0, B2, 1, 1, 32'h88, 0, 0);
    row(0, 32'h0,   0, N,  B2, 32'h99, 0, N,  0, 0, 32'h0,  0, 0);
    row(0, 32'h0,   0, N,  N,  32'h0,  0, N,  0, 1, 32'h99, 0, 0);
    // Response while idle is stray.
    row(0, 32'h0,   0, N,  B1, 32'hAA, 0, N,  0, 0, 32'h0,  0, 0);
    row(0, 32'h0,   0, N,  N,  32'h0,  0, N,  0, 0, 32'h0,  0, 1);

    repeat (2) @(negedge clk_i);
    chk_all_zero("reset");
    rst_ni = 1'b1;

    foreach (tv[k]) begin
      @(posedge clk_i); #1;
      row_no = k;
      drive(tv[k].req, tv[k].add, tv[k].wen, tv[k].gnt, tv[k].rv, tv[k].rdata, tv[k].opc);
      @(negedge clk_i);
      chk("slv_req",  32'(slv_req_o),     32'(tv[k].e_req));
      chk("mst_gnt",  32'(mst_gnt_o),     32'(tv[k].e_gnt));
      chk("r_valid",  32'(mst_r_valid_o), 32'(tv[k].e_rv));
      chk("r_rdata",  mst_r_rdata_o,      tv[k].e_rdata);
      chk("r_opc",    32'(mst_r_opc_o),   32'(tv[k].e_opc));
      chk("stray",    32'(stray_rsp_o),   32'(tv[k].e_stray));
      chk("slv_add",  slv_add_o,          tv[k].add);
    end

    // Mid-operation reset with three timer transactions outstanding.
    row_no = 100;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk_i); #1;
      drive(1, 32'h400, 1, B1, (j == 3) ? B1 : N, 32'hCC, 0);
      @(negedge clk_i);
      chk("pre-rst gnt", 32'(mst_gnt_o), 32'd1);
    end
    @(posedge clk_i); #1;
    drive(0, 32'h0, 0, N, N, 32'h0, 0);
    @(negedge clk_i);
    chk("pre-rst rv",    32'(mst_r_valid_o), 32'd1);
    chk("pre-rst rdata", mst_r_rdata_o,      32'hCC);
    #1 rst_ni = 1'b0;
    #1 chk_all_zero("mid-rst");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    row_no = 101;
    @(posedge clk_i); #1;
    drive(0, 32'h0, 0, N, B1, 32'hDD, 0);
    @(negedge clk_i);
    chk("late rsp stray0", 32'(stray_rsp_o), 32'd0);
    @(posedge clk_i); #1;
    drive(1, 32'h800, 1, B2, N, 32'h0, 0);
    @(negedge clk_i);
    chk("late rsp stray", 32'(stray_rsp_o),   32'd1);
    chk("late rsp rv",    32'(mst_r_valid_o), 32'd0);
    chk("post-rst gnt",   32'(mst_gnt_o),     32'd1);
    chk("post-rst req",   32'(slv_req_o),     32'(B2));
    @(posedge clk_i); #1;
    drive(0, 32'h0, 0, N, N, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cluster_periph_router.md
Name: cluster_periph_router

Overview:
- Sequences access from the cluster peripheral-interconnect master port to the NB_SPERIPHS cluster peripheral slave plugs (EOC, timer, event unit, HWPE, icache ctrl, DMA cluster/FC, decompressor, external, lockstep).
- Decodes the slave index, forwards the req/gnt handshake and tracks outstanding transactions so responses return to the master strictly in order.
- Generates an error response for unmapped slots; sits between the cluster periph interconnect and the peripheral plugs.

Parameters:
- NB_SPERIPHS, 11, number of slave plugs; index range 0..NB_SPERIPHS-1.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- IDX_LSB, 10, LSB of the slave-index field (1 KiB per peripheral).
- MAX_OUTSTANDING, 4, maximum accepted but not yet answered transactions.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mst_req_i  in  1  master request
- mst_add_i  in  ADDR_WIDTH  master address
- mst_wen_i  in  1  1=read, 0=write
- mst_wdata_i  in  DATA_WIDTH  write data
- mst_be_i  in  DATA_WIDTH/8  byte enables
- mst_gnt_o  out  1  grant to master
- mst_r_valid_o  out  1  response valid
- mst_r_rdata_o  out  DATA_WIDTH  response data
- mst_r_opc_o  out  1  response error flag
- slv_req_o  out  NB_SPERIPHS  one-hot request per slave
- slv_add_o, slv_wen_o, slv_wdata_o, slv_be_o  out  as master  broadcast to all slaves
- slv_gnt_i  in  NB_SPERIPHS  per-slave grant
- slv_r_valid_i  in  NB_SPERIPHS  per-slave response valid
- slv_r_rdata_i  in  NB_SPERIPHS x DATA_WIDTH  per-slave response data
- slv_r_opc_i  in  NB_SPERIPHS  per-slave error flag
- stray_rsp_o  out  1  one-cycle pulse on an unexpected slave response

Behaviour:
- Index: idx = mst_add_i[IDX_LSB+3:IDX_LSB]. Unmapped when idx >= NB_SPERIPHS or idx == 3.
- Reset values: all outputs 0; state IDLE; outstanding counter cnt = 0; target register tgt_q = 0.
- States:
  - IDLE: cnt == 0.
  - BUSY: cnt > 0, target = tgt_q.
  - ERR: an error response is pending.
- Forwarding:
  - slv_req_o[idx] = mst_req_i, only when mapped, cnt < MAX_OUTSTANDING, and (IDLE, or BUSY with idx == tgt_q).
  - mst_gnt_o = slv_gnt_i[idx] under the same condition. Combinational; 0-cycle grant latency added.
- Accept (req && gnt):
  - From IDLE: tgt_q <= idx, cnt <= 1, go to BUSY.
  - In BUSY: cnt increments.
- Request to a different target while BUSY: held off (no slv_req_o, no gnt) until cnt drains to 0, then it proceeds from IDLE.
- Responses:
  - mst_r_valid_o/rdata/opc are the registered copy of the slv_r_*_i[tgt_q] outputs, so the router adds exactly 1 cycle.
  - Each slv_r_valid_i[tgt_q] decrements cnt; BUSY returns to IDLE when cnt reaches 0.
  - mst_r_rdata_o is 0 when mst_r_valid_o = 0.
- Simultaneous accept and response in one cycle: cnt unchanged, state stays BUSY.
- Unmapped request:
  - Granted only in IDLE (no slave request driven), then go to ERR.
  - Next cycle: mst_r_valid_o = 1, mst_r_opc_o = 1, mst_r_rdata_o = 32'hBADACCE5, then IDLE.
  - No grant while in ERR.
- Stray response: slv_r_valid_i on a slave other than tgt_q, or any response in IDLE/ERR.
  - Ignored, cnt unchanged; stray_rsp_o pulses for 1 cycle.
- Counter never exceeds MAX_OUTSTANDING and never underflows; a response at cnt == 0 counts as stray.
- Reset mid-operation: all state clears immediately. Responses to transactions accepted before reset are treated as stray.

Decomposition:
- Shared cluster package: SPER_* slave IDs, NB_SPERIPHS, the unmapped-ID set, error data constant ERR_RDATA = 32'hBADACCE5, and router state enum {IDLE, BUSY, ERR}.
- Sub-module: cluster_periph_outstanding_cnt, a saturating up/down counter with inc/dec/full/empty flags.

Test Plan:
- Read timer (add 0x0000_0400), slave grants same cycle, r_valid 1 cycle later with 0x1234 -> slv_req_o = 11'b000_0000_0010; master sees r_valid with rdata 0x1234 one cycle after the slave response; cnt returns to 0.
- Four back-to-back writes to DMA_CL (idx 6), slave responses held off -> 4 grants; 5th request not granted (cnt = 4); first response reopens the grant the same cycle.
- Request to EU (idx 2) while 2 transactions to the timer are outstanding -> no slv_req_o[2] until both timer responses return; EU is granted the cycle cnt == 0.
- Access to idx 3 and to idx 12 -> granted from IDLE; next cycle r_valid = 1, opc = 1, rdata = 0xBADACCE5; no slv_req_o asserted.
- Accept and response in the same cycle with cnt = 2 -> cnt stays 2. Unsolicited slv_r_valid_i[8] while tgt = 1 -> stray_rsp_o pulses, cnt unchanged.
- rst_ni asserted with cnt = 3 -> all outputs 0 and IDLE immediately; a late response after release -> stray_rsp_o = 1 and no mst_r_valid_o.
